// File: rtl/ioctl_upload_reader_if.sv
// HPS ioctl upload bus as seen by a core-side save-file reader.
// The master modport is the HPS side; the slave modport is the reader.
interface ioctl_upload_reader_if;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [26:0] ioctl_addr;
  logic [15:0] ioctl_din;
  logic        ioctl_wait;

  modport master (
    output ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr,
    input  ioctl_din, ioctl_wait
  );

  modport slave (
    input  ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr,
    output ioctl_din, ioctl_wait
  );
endinterface

// File: rtl/ioctl_upload_reader.sv
// Serves HPS 16-bit upload reads (NVRAM/hiscore save) from a byte-wide core RAM
// with a fixed read latency, holding the core CPU while the upload is active.
module ioctl_upload_reader #(
  parameter logic [7:0] UPLOAD_INDEX = 8'd4,
  parameter int         ADDR_W       = 12,
  parameter int         RAM_LAT      = 1
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  ioctl_upload_reader_if.slave ioctl,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_rd,
  input  logic [7:0]          mem_dout,
  output logic                pause,
  output logic                upload_done
);
  localparam int CNT_W = $clog2(RAM_LAT + 1);

  typedef enum logic [2:0] {IDLE, RD_LO, WAIT_LO, RD_HI, WAIT_HI, OOR} state_e;

  state_e            state_q,    state_d;
  logic [CNT_W-1:0]  lat_cnt_q,  lat_cnt_d;
  logic [7:0]        lo_q,       lo_d;
  logic [15:0]       din_q,      din_d;
  logic              wait_q,     wait_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_q,   mem_rd_d;
  logic              pause_q,    pause_d;
  logic              done_q,     done_d;

  logic active;
  logic addr_oor;
  logic lat_hit;

  assign active   = ioctl.ioctl_upload & (ioctl.ioctl_index == UPLOAD_INDEX);
  assign addr_oor = (ioctl.ioctl_addr >> ADDR_W) != '0;
  // Counter is loaded with 1 on entry to a wait state, so reaching RAM_LAT
  // marks the edge on which the RAM data is valid.
  assign lat_hit  = (lat_cnt_q == CNT_W'(RAM_LAT));

  always_comb begin
    // NOTE: every _d takes its held value first, so no path through the
    // case below can leave one unassigned and infer a latch.
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    lo_d       = lo_q;
    din_d      = din_q;
    wait_d     = wait_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = 1'b0;
    pause_d    = active;
    done_d     = pause_q & ~active;

    if (state_q != IDLE && !active) begin
      // Session ended mid-read: drop the transfer, keep the last returned word.
      state_d = IDLE;
      wait_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ioctl.ioctl_rd && active) begin
            wait_d = 1'b1;
            if (addr_oor) begin
              state_d = OOR;
            end else begin
              state_d    = RD_LO;
              mem_addr_d = {ioctl.ioctl_addr[ADDR_W-1:1], 1'b0};
              mem_rd_d   = 1'b1;
            end
          end
        end
        RD_LO: begin
          state_d   = WAIT_LO;
          lat_cnt_d = CNT_W'(1);
        end
        WAIT_LO: begin
          if (lat_hit) begin
            lo_d       = mem_dout;
            state_d    = RD_HI;
            mem_addr_d = {mem_addr_q[ADDR_W-1:1], 1'b1};
            mem_rd_d   = 1'b1;
          end else begin
            lat_cnt_d = lat_cnt_q + CNT_W'(1);
          end
        end
        RD_HI: begin
          state_d   = WAIT_HI;
          lat_cnt_d = CNT_W'(1);
        end
        WAIT_HI: begin
          if (lat_hit) begin
            din_d   = {mem_dout, lo_q};
            wait_d  = 1'b0;
            state_d = IDLE;
          end else begin
            lat_cnt_d = lat_cnt_q + CNT_W'(1);
          end
        end
        OOR: begin
          din_d   = 16'hFFFF;
          wait_d  = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      lat_cnt_q  <= '0;
      lo_q       <= '0;
      din_q      <= '0;
      wait_q     <= 1'b0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      pause_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      lo_q       <= lo_d;
      din_q      <= din_d;
      wait_q     <= wait_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      pause_q    <= pause_d;
      done_q     <= done_d;
    end
  end

  assign ioctl.ioctl_din  = din_q;
  assign ioctl.ioctl_wait = wait_q;
  assign mem_addr         = mem_addr_q;
  assign mem_rd           = mem_rd_q;
  assign pause            = pause_q;
  assign upload_done      = done_q;
endmodule

// File: tb/tb_ioctl_upload_reader.sv
// Bench for ioctl_upload_reader: a RAM_LAT=1 and a RAM_LAT=3 instance share one
// HPS stimulus stream; a transaction-level model predicts each read.
`timescale 1ns/1ps
module tb_ioctl_upload_reader;
  localparam int ADDR_W = 12;

  logic clk_sys;
  logic reset_n;
  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        upload;
  logic [7:0]  index;
  logic        rd;
  logic [26:0] addr;

  ioctl_upload_reader_if bus1();
  ioctl_upload_reader_if bus3();
  assign bus1.ioctl_upload = upload;
  assign bus1.ioctl_index  = index;
  assign bus1.ioctl_rd     = rd;
  assign bus1.ioctl_addr   = addr;
  assign bus3.ioctl_upload = upload;
  assign bus3.ioctl_index  = index;
  assign bus3.ioctl_rd     = rd;
  assign bus3.ioctl_addr   = addr;

  logic [ADDR_W-1:0] mem_addr1, mem_addr3;
  logic              mem_rd1, mem_rd3;
  logic [7:0]        mem_dout1, mem_dout3;
  logic              pause1, pause3, done1, done3;

  ioctl_upload_reader #(.UPLOAD_INDEX(8'd4), .ADDR_W(ADDR_W), .RAM_LAT(1)) dut1 (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl(bus1),
    .mem_addr(mem_addr1), .mem_rd(mem_rd1), .mem_dout(mem_dout1),
    .pause(pause1), .upload_done(done1));

  ioctl_upload_reader #(.UPLOAD_INDEX(8'd4), .ADDR_W(ADDR_W), .RAM_LAT(3)) dut3 (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl(bus3),
    .mem_addr(mem_addr3), .mem_rd(mem_rd3), .mem_dout(mem_dout3),
    .pause(pause3), .upload_done(done3));

  // Core RAM: data is valid for exactly one cycle, RAM_LAT edges after the strobe.
  logic [7:0] ram [0:4095];
  logic [7:0] d1;
  logic [7:0] d3 [0:2];
  always @(posedge clk_sys) begin
    d1    <= mem_rd1 ? ram[mem_addr1] : 8'($urandom);
    d3[0] <= mem_rd3 ? ram[mem_addr3] : 8'($urandom);
    d3[1] <= d3[0];
    d3[2] <= d3[1];
  end
  assign mem_dout1 = d1;
  assign mem_dout3 = d3[2];

  // Observed DUT selector: 0 -> RAM_LAT=1 instance, 1 -> RAM_LAT=3 instance.
  int                sel;
  logic              m_wait, m_rd, m_pause, m_done;
  logic [15:0]       m_din;
  logic [ADDR_W-1:0] m_addr;
  always_comb begin
    if (sel == 1) begin
      m_wait = bus3.ioctl_wait; m_din = bus3.ioctl_din; m_rd = mem_rd3;
      m_addr = mem_addr3; m_pause = pause3; m_done = done3;
    end else begin
      m_wait = bus1.ioctl_wait; m_din = bus1.ioctl_din; m_rd = mem_rd1;
      m_addr = mem_addr1; m_pause = pause1; m_done = done1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic set_sel(input int s);
    sel = s;
    #1;
  endtask

  task automatic settle();
    rd = 1'b0;
    for (int i = 0; i < 20 && (bus1.ioctl_wait || bus3.ioctl_wait); i++) tick();
    tick();
  endtask

  // One HPS word read on the selected instance, compared against the model.
  task automatic do_read(input logic [26:0] a, input bit extra_rd, input string tag);
    int                lat;
    logic [15:0]       exp_din;
    int                exp_wait, exp_n, exp_k1;
    logic [ADDR_W-1:0] base;
    logic [15:0]       din_before;
    int                k, wait_cnt;
    bit                din_moved;
    int                rd_k[$];
    logic [ADDR_W-1:0] rd_a[$];

    lat = (sel == 1) ? 3 : 1;
    base = a[ADDR_W-1:0] & ~ADDR_W'(1);
    exp_k1 = 1 + lat;
    if ((a >> ADDR_W) != 0) begin
      exp_din = 16'hFFFF; exp_wait = 1; exp_n = 0;
    end else begin
      exp_din = {ram[base | ADDR_W'(1)], ram[base]}; exp_wait = 2 + 2 * lat; exp_n = 2;
    end

    din_before = m_din;
    k = 0; wait_cnt = 0; din_moved = 1'b0;
    rd = 1'b1; addr = a;
    tick();
    rd = 1'b0; addr = 27'($urandom);
    while (m_wait && k < 40) begin
      wait_cnt++;
      if (m_rd) begin rd_k.push_back(k); rd_a.push_back(m_addr); end
      if (m_din !== din_before) din_moved = 1'b1;
      if (extra_rd && k == 2) begin rd = 1'b1; addr = 27'h10; end
      else rd = 1'b0;
      tick();
      k++;
    end
    rd = 1'b0;
    if (m_rd) begin rd_k.push_back(k); rd_a.push_back(m_addr); end

    n_checks++;
    if (k >= 40) begin
      n_fail++; $display("FAIL %s timeout: wait still high after %0d cycles", tag, k);
    end
    n_checks++;
    if (wait_cnt != exp_wait) begin
      n_fail++; $display("FAIL %s wait_cycles got=%0d exp=%0d", tag, wait_cnt, exp_wait);
    end
    n_checks++;
    if (m_din !== exp_din) begin
      n_fail++; $display("FAIL %s din got=%h exp=%h", tag, m_din, exp_din);
    end
    n_checks++;
    if (din_moved) begin
      n_fail++; $display("FAIL %s din_hold changed during wait, before=%h", tag, din_before);
    end
    n_checks++;
    if (rd_k.size() != exp_n) begin
      n_fail++; $display("FAIL %s mem_rd_count got=%0d exp=%0d", tag, rd_k.size(), exp_n);
    end else if (exp_n == 2 && (rd_k[0] != 0 || rd_a[0] !== base ||
                                rd_k[1] != exp_k1 || rd_a[1] !== (base | ADDR_W'(1)))) begin
      n_fail++;
      $display("FAIL %s mem_rd_seq got=(%0d,%h)(%0d,%h) exp=(0,%h)(%0d,%h)", tag,
               rd_k[0], rd_a[0], rd_k[1], rd_a[1], base, exp_k1, base | ADDR_W'(1));
    end
    settle();
  endtask

  task automatic test_reset();
    int bad;
    upload = 1'b0; index = 8'd0; rd = 1'b0; addr = '0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({bus1.ioctl_din, bus1.ioctl_wait, mem_rd1, mem_addr1, pause1, done1} !== '0) begin
      n_fail++; $display("FAIL reset_lat1 din=%h wait=%b rd=%b addr=%h pause=%b done=%b",
                         bus1.ioctl_din, bus1.ioctl_wait, mem_rd1, mem_addr1, pause1, done1);
    end
    n_checks++;
    if ({bus3.ioctl_din, bus3.ioctl_wait, mem_rd3, mem_addr3, pause3, done3} !== '0) begin
      n_fail++; $display("FAIL reset_lat3 din=%h wait=%b rd=%b addr=%h pause=%b done=%b",
                         bus3.ioctl_din, bus3.ioctl_wait, mem_rd3, mem_addr3, pause3, done3);
    end
    repeat (2) @(posedge clk_sys);
    #1 reset_n = 1'b1;
    tick();
    // Read request with no upload session must be ignored.
    bad = 0;
    rd = 1'b1; addr = 27'h10;
    tick();
    rd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus1.ioctl_wait || bus3.ioctl_wait || mem_rd1 || mem_rd3) bad++;
      tick();
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL rd_no_upload busy_cycles got=%0d exp=0", bad);
    end
  endtask

  task automatic test_index_and_pause();
    int bad;
    set_sel(0);
    index = 8'd3; upload = 1'b1;
    tick();
    bad = 0;
    rd = 1'b1; addr = 27'h20;
    tick();
    rd = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (m_wait || m_rd || m_pause || bus3.ioctl_wait || mem_rd3 || pause3) bad++;
      tick();
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL wrong_index active_cycles got=%0d exp=0", bad);
    end
    upload = 1'b0;
    tick();
    n_checks++;
    if (m_done !== 1'b0) begin
      n_fail++; $display("FAIL wrong_index_done got=%b exp=0", m_done);
    end
    index = 8'd4; upload = 1'b1;
    n_checks++;
    if (m_pause !== 1'b0) begin
      n_fail++; $display("FAIL pause_before_edge got=%b exp=0", m_pause);
    end
    tick();
    n_checks++;
    if (m_pause !== 1'b1 || pause3 !== 1'b1) begin
      n_fail++; $display("FAIL pause_after_edge got=%b/%b exp=1/1", m_pause, pause3);
    end
  endtask

  task automatic test_directed();
    set_sel(0);
    ram[12'h010] = 8'h34; ram[12'h011] = 8'h12;
    do_read(27'h010, 1'b0, "directed_0x010");
    n_checks++;
    if (bus1.ioctl_din !== 16'h1234) begin
      n_fail++; $display("FAIL directed_literal din got=%h exp=1234", bus1.ioctl_din);
    end
  endtask

  task automatic test_oor();
    set_sel(0);
    do_read(27'h1000, 1'b0, "oor_0x1000_lat1");
    set_sel(1);
    do_read(27'h7FF_FFFF, 1'b0, "oor_top_lat3");
  endtask

  task automatic test_lat3();
    set_sel(1);
    ram[12'h7FE] = 8'($urandom); ram[12'h7FF] = 8'($urandom);
    do_read(27'h7FE, 1'b1, "lat3_0x7FE_extra_rd");
  endtask

  task automatic test_random();
    logic [26:0] a;
    for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
    for (int n = 0; n < 24; n++) begin
      set_sel(int'($urandom_range(0, 1)));
      if ($urandom_range(0, 5) == 0) a = {15'($urandom_range(1, 32767)), 12'($urandom)};
      else a = 27'($urandom_range(0, 4095));
      do_read(a, bit'($urandom_range(0, 1)), $sformatf("random_%0d_sel%0d_a%h", n, sel, a));
    end
  endtask

  task automatic test_abort();
    logic [15:0] din_before;
    int n_rd, n_done;
    set_sel(0);
    din_before = m_din;
    n_rd = 0; n_done = 0;
    rd = 1'b1; addr = 27'h2A4;
    tick();
    rd = 1'b0;
    n_rd += int'(m_rd); n_done += int'(m_done);
    tick();
    n_rd += int'(m_rd); n_done += int'(m_done);
    n_checks++;
    if (m_wait !== 1'b1) begin
      n_fail++; $display("FAIL abort_inflight wait got=%b exp=1", m_wait);
    end
    upload = 1'b0;
    tick();
    n_rd += int'(m_rd); n_done += int'(m_done);
    n_checks++;
    if (m_wait !== 1'b0 || m_rd !== 1'b0 || m_done !== 1'b1 || m_pause !== 1'b0) begin
      n_fail++; $display("FAIL abort_edge wait=%b rd=%b done=%b pause=%b exp 0,0,1,0",
                         m_wait, m_rd, m_done, m_pause);
    end
    n_checks++;
    if (m_din !== din_before) begin
      n_fail++; $display("FAIL abort_din got=%h exp=%h", m_din, din_before);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_rd += int'(m_rd); n_done += int'(m_done);
    end
    n_checks++;
    if (n_rd != 1 || n_done != 1) begin
      n_fail++; $display("FAIL abort_counts mem_rd=%0d done=%0d exp 1,1", n_rd, n_done);
    end
    settle();
  endtask

  task automatic test_reset_mid_session();
    int bad;
    set_sel(0);
    index = 8'd4; upload = 1'b1;
    tick(); tick();
    ram[12'h010] = 8'h34; ram[12'h011] = 8'h12;
    rd = 1'b1; addr = 27'h010;
    tick();
    rd = 1'b0;
    tick(); tick(); tick();
    n_checks++;
    if (m_wait !== 1'b1 || m_pause !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_wait_hi wait=%b pause=%b exp 1,1", m_wait, m_pause);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({m_din, m_wait, m_rd, m_addr, m_pause, m_done} !== '0) begin
      n_fail++; $display("FAIL reset_in_wait_hi din=%h wait=%b rd=%b addr=%h pause=%b done=%b",
                         m_din, m_wait, m_rd, m_addr, m_pause, m_done);
    end
    @(posedge clk_sys); @(posedge clk_sys);
    #1 reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (m_done || done3) bad++;
    end
    n_checks++;
    if (bad != 0 || m_pause !== 1'b1) begin
      n_fail++; $display("FAIL post_reset done_cycles=%0d pause=%b exp 0,1", bad, m_pause);
    end
    do_read(27'h010, 1'b0, "first_rd_after_reset");
    upload = 1'b0;
    tick();
    n_checks++;
    if (m_done !== 1'b1) begin
      n_fail++; $display("FAIL end_of_upload_done got=%b exp=1", m_done);
    end
    tick();
    n_checks++;
    if (m_done !== 1'b0) begin
      n_fail++; $display("FAIL done_one_cycle got=%b exp=0", m_done);
    end
  endtask

  initial begin
    sel = 0;
    test_reset();
    test_index_and_pause();
    test_directed();
    test_oor();
    test_lat3();
    test_random();
    test_abort();
    upload = 1'b1; index = 8'd4;
    tick();
    test_reset_mid_session();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end
endmodule
